// File: rtl/voice_allocator.sv
// voice_allocator
//   Shares a pool of NUM_VOICES oscillator voices among note-on/note-off events.
//   Each event goes through IDLE -> LOOKUP -> APPLY, so one event is accepted
//   every 3 cycles. Voice outputs and the pulses change on the edge leaving APPLY.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   ev_valid/ready  event handshake; ev_ready is high only in IDLE
//   ev_on           1 = note-on, 0 = note-off
//   ev_note         note identifier
//   ev_freq         frequency word for note-on (0 is rejected)
//   voice_freq      per-voice frequency; voice i at [i*FREQ_W +: FREQ_W]
//   voice_gate      per-voice key-held flag
//   voice_active    per-voice gated-or-releasing flag
//   steal_pulse     one cycle when a busy voice is reassigned
//   drop_pulse      one cycle when an event has no effect
module voice_allocator #(
    parameter int NUM_VOICES     = 4,
    parameter int NOTE_W         = 7,
    parameter int FREQ_W         = 12,
    parameter int RELEASE_CYCLES = 1000,
    parameter int AGE_W          = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [FREQ_W-1:0]            ev_freq,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         steal_pulse,
    output logic                         drop_pulse
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    // The +2 keeps at least one bit and always leaves room for the load value.
    localparam int REL_W = $clog2(RELEASE_CYCLES + 2);
    localparam logic [REL_W-1:0]  REL_LOAD   = REL_W'(RELEASE_CYCLES);
    localparam logic [FREQ_W-1:0] RESET_FREQ = FREQ_W'(440);
    localparam logic [AGE_W-1:0]  AGE_MAX    = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;

    state_t              state_q, state_d;
    logic                ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]   ev_note_q, ev_note_d;
    logic [FREQ_W-1:0]   ev_freq_q, ev_freq_d;

    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic                sel_hit_q, sel_hit_d;
    logic                sel_steal_q, sel_steal_d;
    logic                sel_drop_q, sel_drop_d;

    logic [NOTE_W-1:0]   note_q [NUM_VOICES];
    logic [NOTE_W-1:0]   note_d [NUM_VOICES];
    logic [FREQ_W-1:0]   freq_q [NUM_VOICES];
    logic [FREQ_W-1:0]   freq_d [NUM_VOICES];
    logic [AGE_W-1:0]    age_q  [NUM_VOICES];
    logic [AGE_W-1:0]    age_d  [NUM_VOICES];
    logic [REL_W-1:0]    rel_q  [NUM_VOICES];
    logic [REL_W-1:0]    rel_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d, active_q, active_d;
    logic                steal_q, steal_d, drop_q, drop_d;

    logic                match_found, free_found, off_found, rel_found, gat_found;
    logic [IDX_W-1:0]    match_idx, free_idx, off_idx, rel_idx, gat_idx;
    logic [AGE_W-1:0]    rel_age, gat_age;
    logic                cand_hit, cand_steal, cand_drop;
    logic [IDX_W-1:0]    cand_idx;

    // Candidate search. First-found flags give lowest-index priority; the strict
    // age comparison keeps the lowest index when ages tie.
    always_comb begin
        match_found = 1'b0; match_idx = '0;
        free_found  = 1'b0; free_idx  = '0;
        off_found   = 1'b0; off_idx   = '0;
        rel_found   = 1'b0; rel_idx   = '0; rel_age = '0;
        gat_found   = 1'b0; gat_idx   = '0; gat_age = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && note_q[i] == ev_note_q && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!active_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (gate_q[i] && note_q[i] == ev_note_q && !off_found) begin
                off_found = 1'b1;
                off_idx   = IDX_W'(i);
            end
            if (active_q[i] && !gate_q[i] && (!rel_found || age_q[i] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
                rel_age   = age_q[i];
            end
            if (gate_q[i] && (!gat_found || age_q[i] > gat_age)) begin
                gat_found = 1'b1;
                gat_idx   = IDX_W'(i);
                gat_age   = age_q[i];
            end
        end

        cand_hit   = 1'b0;
        cand_steal = 1'b0;
        cand_drop  = 1'b0;
        cand_idx   = '0;
        if (ev_on_q) begin
            // A zero frequency would make the oscillator divide by zero.
            if (ev_freq_q == '0) begin
                cand_drop = 1'b1;
            end else if (match_found) begin
                cand_hit = 1'b1;
                cand_idx = match_idx;
            end else if (free_found) begin
                cand_hit = 1'b1;
                cand_idx = free_idx;
            end else begin
                // No free voice means every voice is active, so a gated
                // voice always exists when nothing is releasing.
                cand_hit   = 1'b1;
                cand_steal = 1'b1;
                cand_idx   = rel_found ? rel_idx : gat_idx;
            end
        end else if (off_found) begin
            cand_hit = 1'b1;
            cand_idx = off_idx;
        end else begin
            cand_drop = 1'b1;
        end
    end

    // Event FSM: latch in IDLE, register the candidates in LOOKUP, apply in APPLY.
    always_comb begin
        state_d     = state_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        ev_freq_d   = ev_freq_q;
        sel_idx_d   = sel_idx_q;
        sel_hit_d   = sel_hit_q;
        sel_steal_d = sel_steal_q;
        sel_drop_d  = sel_drop_q;
        ev_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) begin
                    ev_on_d   = ev_on;
                    ev_note_d = ev_note;
                    ev_freq_d = ev_freq;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                sel_idx_d   = cand_idx;
                sel_hit_d   = cand_hit;
                sel_steal_d = cand_steal;
                sel_drop_d  = cand_drop;
                state_d     = APPLY;
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-voice ageing and release countdown, then the APPLY update on top so
    // that an event wins over a release expiring in the same cycle.
    always_comb begin
        steal_d  = (state_q == APPLY) && sel_steal_q;
        drop_d   = (state_q == APPLY) && sel_drop_q;
        gate_d   = gate_q;
        active_d = active_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_d[i] = note_q[i];
            freq_d[i] = freq_q[i];
            age_d[i]  = age_q[i];
            rel_d[i]  = rel_q[i];
            if (active_q[i]) begin
                if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
                if (!gate_q[i]) begin
                    if (rel_q[i] <= REL_W'(1)) begin
                        active_d[i] = 1'b0;
                        rel_d[i]    = '0;
                        age_d[i]    = '0;
                    end else begin
                        rel_d[i] = rel_q[i] - REL_W'(1);
                    end
                end
            end
            if (state_q == APPLY && sel_hit_q && sel_idx_q == IDX_W'(i)) begin
                if (ev_on_q) begin
                    note_d[i]   = ev_note_q;
                    freq_d[i]   = ev_freq_q;
                    gate_d[i]   = 1'b1;
                    active_d[i] = 1'b1;
                    age_d[i]    = '0;
                    rel_d[i]    = '0;
                end else begin
                    gate_d[i] = 1'b0;
                    rel_d[i]  = REL_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_freq_q   <= '0;
            sel_idx_q   <= '0;
            sel_hit_q   <= 1'b0;
            sel_steal_q <= 1'b0;
            sel_drop_q  <= 1'b0;
            gate_q      <= '0;
            active_q    <= '0;
            steal_q     <= 1'b0;
            drop_q      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                freq_q[i] <= RESET_FREQ;
                age_q[i]  <= '0;
                rel_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            ev_freq_q   <= ev_freq_d;
            sel_idx_q   <= sel_idx_d;
            sel_hit_q   <= sel_hit_d;
            sel_steal_q <= sel_steal_d;
            sel_drop_q  <= sel_drop_d;
            gate_q      <= gate_d;
            active_q    <= active_d;
            steal_q     <= steal_d;
            drop_q      <= drop_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                freq_q[i] <= freq_d[i];
                age_q[i]  <= age_d[i];
                rel_q[i]  <= rel_d[i];
            end
        end
    end

    always_comb begin
        voice_freq = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_freq[i*FREQ_W +: FREQ_W] = freq_q[i];
        end
    end

    assign voice_gate   = gate_q;
    assign voice_active = active_q;
    assign steal_pulse  = steal_q;
    assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Directed bench for voice_allocator (4 voices, RELEASE_CYCLES = 10).
//   A behavioural model tracks every voice from the allocation rules and is
//   compared against all DUT outputs on each falling edge; directed steps add
//   hand-computed literal expectations.
module tb_voice_allocator;
    localparam int NV      = 4;
    localparam int NW      = 7;
    localparam int FW      = 12;
    localparam int RC      = 10;
    localparam int AGE_MAX = 65535;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NW-1:0]     ev_note;
    logic [FW-1:0]     ev_freq;
    logic [NV*FW-1:0]  voice_freq;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_active;
    logic              steal_pulse;
    logic              drop_pulse;

    int errors = 0;
    int checks = 0;
    int ready_low = 0;
    bit cmp_en = 1'b0;

    voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .FREQ_W(FW), .RELEASE_CYCLES(RC), .AGE_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq),
        .voice_freq(voice_freq), .voice_gate(voice_gate), .voice_active(voice_active),
        .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [NW-1:0] m_note [NV];
    logic [FW-1:0] m_freq [NV];
    bit            m_gate [NV];
    bit            m_active [NV];
    int            m_age [NV];
    int            m_rel [NV];
    int            m_wait;
    bit            m_on;
    logic [NW-1:0] m_ev_note;
    logic [FW-1:0] m_ev_freq;
    int            d_kind;
    int            d_idx;
    bit            m_steal;
    bit            m_drop;

    function automatic logic [NV*FW-1:0] pack4(input int f3, input int f2, input int f1, input int f0);
        logic [FW-1:0] a, b, c, d;
        a = FW'(f3); b = FW'(f2); c = FW'(f1); d = FW'(f0);
        return {a, b, c, d};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Decision: d_kind 0 = drop, 1 = place/retrigger/release, 2 = steal
    task automatic modelDecide();
        int best;
        int score;
        int best_score;
        d_kind = 0;
        d_idx  = 0;
        best   = -1;
        if (m_on) begin
            if (m_ev_freq == 0) return;
            for (int i = NV - 1; i >= 0; i--)
                if (m_active[i] && m_note[i] == m_ev_note) best = i;
            if (best < 0)
                for (int i = NV - 1; i >= 0; i--)
                    if (!m_active[i]) best = i;
            if (best >= 0) begin
                d_kind = 1;
                d_idx  = best;
                return;
            end
            // Releasing voices outrank any gated voice; within a class the
            // larger age wins and equal scores keep the first index.
            best_score = -1;
            for (int i = 0; i < NV; i++) begin
                score = m_age[i] + ((m_active[i] && !m_gate[i]) ? (1 << 20) : 0);
                if (score > best_score) begin
                    best_score = score;
                    best = i;
                end
            end
            d_kind = 2;
            d_idx  = best;
        end else begin
            for (int i = NV - 1; i >= 0; i--)
                if (m_gate[i] && m_note[i] == m_ev_note) begin
                    d_kind = 1;
                    d_idx  = i;
                end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                m_note[i] = '0; m_freq[i] = FW'(440);
                m_gate[i] = 0; m_active[i] = 0; m_age[i] = 0; m_rel[i] = 0;
            end
            m_wait = 0; m_on = 0; m_ev_note = '0; m_ev_freq = '0;
            d_kind = 0; d_idx = 0; m_steal = 0; m_drop = 0;
        end else begin
            if (m_wait == 2) modelDecide();
            for (int i = 0; i < NV; i++) begin
                if (m_active[i]) begin
                    m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                    if (!m_gate[i]) begin
                        if (m_rel[i] <= 1) begin
                            m_active[i] = 0; m_rel[i] = 0; m_age[i] = 0;
                        end else begin
                            m_rel[i] = m_rel[i] - 1;
                        end
                    end
                end
            end
            m_steal = 0;
            m_drop  = 0;
            if (m_wait == 1) begin
                if (d_kind == 0) begin
                    m_drop = 1;
                end else if (m_on) begin
                    m_note[d_idx] = m_ev_note; m_freq[d_idx] = m_ev_freq;
                    m_gate[d_idx] = 1; m_active[d_idx] = 1; m_age[d_idx] = 0; m_rel[d_idx] = 0;
                    m_steal = (d_kind == 2);
                end else begin
                    m_gate[d_idx] = 0;
                    m_rel[d_idx]  = RC;
                end
            end
            if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (ev_valid) begin
                m_on = ev_on; m_ev_note = ev_note; m_ev_freq = ev_freq;
                m_wait = 2;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NV*FW-1:0] ef;
            logic [NV-1:0]    eg, ea;
            for (int i = 0; i < NV; i++) begin
                ef[i*FW +: FW] = m_freq[i];
                eg[i] = m_gate[i];
                ea[i] = m_active[i];
            end
            checkOutput("cmp_ev_ready", 64'(ev_ready), 64'(m_wait == 0));
            checkOutput("cmp_voice_freq", 64'(voice_freq), 64'(ef));
            checkOutput("cmp_voice_gate", 64'(voice_gate), 64'(eg));
            checkOutput("cmp_voice_active", 64'(voice_active), 64'(ea));
            checkOutput("cmp_steal_pulse", 64'(steal_pulse), 64'(m_steal));
            checkOutput("cmp_drop_pulse", 64'(drop_pulse), 64'(m_drop));
        end
    end

    // Drives one event, waits for the transfer and returns on the falling
    // edge after the APPLY edge, when outputs and pulses are visible.
    task automatic applyStimulus(input bit on, input int note, input int freq);
        int waited;
        waited = 0;
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NW'(note);
        ev_freq  = FW'(freq);
        while (!ev_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ev_ready) begin
            checkOutput("handshake_timeout", 64'(ev_ready), 64'(1));
            ev_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ready_low = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ev_valid = 1'b0;
            if (!ev_ready) ready_low++;
        end
    endtask

    task automatic resetDut();
        #2;
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_freq"}, 64'(voice_freq), 64'(pack4(440, 440, 440, 440)));
        checkOutput({tag, "_gate"}, 64'(voice_gate), 64'(0));
        checkOutput({tag, "_active"}, 64'(voice_active), 64'(0));
        checkOutput({tag, "_ready"}, 64'(ev_ready), 64'(1));
        checkOutput({tag, "_steal"}, 64'(steal_pulse), 64'(0));
        checkOutput({tag, "_drop"}, 64'(drop_pulse), 64'(0));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_freq = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        $display("[TB] reset values and first note-on");
        checkResetValues("reset");
        applyStimulus(1, 60, 262);
        checkOutput("first_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 262)));
        checkOutput("first_gate", 64'(voice_gate), 64'(4'b0001));
        checkOutput("first_active", 64'(voice_active), 64'(4'b0001));
        checkOutput("ready_low_cycles", 64'(ready_low), 64'(2));
        checkOutput("first_no_steal", 64'(steal_pulse), 64'(0));
        checkOutput("first_no_drop", 64'(drop_pulse), 64'(0));

        $display("[TB] fill all voices then steal the oldest");
        resetDut();
        applyStimulus(1, 60, 262);
        applyStimulus(1, 64, 330);
        applyStimulus(1, 67, 392);
        applyStimulus(1, 72, 523);
        checkOutput("fill_freq", 64'(voice_freq), 64'(pack4(523, 392, 330, 262)));
        checkOutput("fill_no_steal", 64'(steal_pulse), 64'(0));
        applyStimulus(1, 76, 659);
        checkOutput("steal_gated_freq", 64'(voice_freq), 64'(pack4(523, 392, 330, 659)));
        checkOutput("steal_gated_pulse", 64'(steal_pulse), 64'(1));
        @(negedge clk);
        checkOutput("steal_pulse_once", 64'(steal_pulse), 64'(0));

        $display("[TB] releasing voice is stolen before gated voices");
        applyStimulus(0, 64, 0);
        checkOutput("off64_gate", 64'(voice_gate), 64'(4'b1101));
        checkOutput("off64_active", 64'(voice_active), 64'(4'b1111));
        checkOutput("off64_freq_kept", 64'(voice_freq), 64'(pack4(523, 392, 330, 659)));
        applyStimulus(1, 80, 700);
        checkOutput("steal_rel_freq", 64'(voice_freq), 64'(pack4(523, 392, 700, 659)));
        checkOutput("steal_rel_pulse", 64'(steal_pulse), 64'(1));
        checkOutput("steal_rel_gate", 64'(voice_gate), 64'(4'b1111));

        $display("[TB] release window length");
        applyStimulus(0, 67, 0);
        cnt = 0;
        while (voice_active[2] && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("release_window", 64'(cnt), 64'(RC));
        checkOutput("released_active", 64'(voice_active), 64'(4'b1011));
        checkOutput("released_freq_kept", 64'(voice_freq), 64'(pack4(523, 392, 700, 659)));

        $display("[TB] retrigger");
        resetDut();
        applyStimulus(1, 60, 262);
        applyStimulus(1, 60, 270);
        checkOutput("retrig_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 270)));
        checkOutput("retrig_no_steal", 64'(steal_pulse), 64'(0));
        checkOutput("retrig_count", 64'($countones(voice_active)), 64'(1));
        applyStimulus(0, 60, 0);
        applyStimulus(1, 60, 300);
        checkOutput("retrig_rel_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 300)));
        checkOutput("retrig_rel_gate", 64'(voice_gate), 64'(4'b0001));
        checkOutput("retrig_rel_no_steal", 64'(steal_pulse), 64'(0));

        $display("[TB] dropped events");
        applyStimulus(0, 50, 0);
        checkOutput("drop_off_pulse", 64'(drop_pulse), 64'(1));
        checkOutput("drop_off_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 300)));
        checkOutput("drop_off_gate", 64'(voice_gate), 64'(4'b0001));
        applyStimulus(1, 61, 0);
        checkOutput("drop_zero_pulse", 64'(drop_pulse), 64'(1));
        checkOutput("drop_zero_active", 64'(voice_active), 64'(4'b0001));
        checkOutput("drop_zero_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 300)));
        applyStimulus(0, 60, 0);
        checkOutput("off60_no_drop", 64'(drop_pulse), 64'(0));
        applyStimulus(0, 60, 0);
        checkOutput("drop_releasing_pulse", 64'(drop_pulse), 64'(1));
        checkOutput("drop_releasing_gate", 64'(voice_gate), 64'(4'b0000));
        checkOutput("drop_releasing_active", 64'(voice_active), 64'(4'b0001));

        $display("[TB] reset during lookup");
        resetDut();
        applyStimulus(1, 60, 262);
        applyStimulus(1, 62, 294);
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = NW'(64); ev_freq = FW'(330);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        checkOutput("lookup_ready_low", 64'(ev_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 65, 349);
        checkOutput("post_reset_freq", 64'(voice_freq), 64'(pack4(440, 440, 440, 349)));
        checkOutput("post_reset_gate", 64'(voice_gate), 64'(4'b0001));
        checkOutput("post_reset_active", 64'(voice_active), 64'(4'b0001));

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Shares a fixed pool of sine oscillator voices among incoming note-on/note-off events from the keyboard/sequencer front end.
- Drives each voice's 12-bit frequency word and a gate/active pair for the envelope and mixer stages.
- Handles retrigger, free-voice allocation, release hold-off and voice stealing.
- Sits between the event source and the bank of oscillators.

Parameters:
- NUM_VOICES, 4: number of oscillator voices managed (2..8).
- NOTE_W, 7: width of the note identifier.
- FREQ_W, 12: width of the frequency word delivered to each oscillator, in Hz.
- RELEASE_CYCLES, 1000: cycles a voice stays reserved after note-off before it is freed.
- AGE_W, 16: width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock (1 MHz)
- rst_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event this cycle
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note identifier
- ev_freq  in  FREQ_W  frequency for note-on; ignored for note-off
- voice_freq  out  NUM_VOICES*FREQ_W  per-voice frequency word; voice i occupies bits [i*FREQ_W +: FREQ_W]
- voice_gate  out  NUM_VOICES  1 while the key is held
- voice_active  out  NUM_VOICES  1 while gated or releasing
- steal_pulse  out  1  one-cycle pulse when a held or releasing voice is reassigned
- drop_pulse  out  1  one-cycle pulse when an event is consumed with no effect

Behaviour:
- One clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values:
  - voice_freq of every voice = 440.
  - voice_gate = 0, voice_active = 0.
  - All per-voice note ids = 0, age = 0, release counters = 0.
  - steal_pulse = 0, drop_pulse = 0.
  - FSM = IDLE, ev_ready = 1.
- FSM states IDLE -> LOOKUP -> APPLY -> IDLE:
  - IDLE: ev_ready = 1. A transfer occurs when ev_valid && ev_ready; ev_on, ev_note and ev_freq are latched and the FSM moves to LOOKUP.
  - LOOKUP: ev_ready = 0. Registers match, free and steal candidates.
  - APPLY: ev_ready = 0. Updates the selected voice and pulses steal_pulse or drop_pulse, then returns to IDLE.
  - Throughput: one event per 3 cycles. Outputs change on the clock edge that leaves APPLY.
- Note-on selection priority:
  1. Active voice with the same note id (gated or releasing): retrigger it. Set gate = 1, load the new freq, age = 0, cancel the release. Not a steal.
  2. Otherwise the lowest-index inactive voice.
  3. Otherwise steal. Choose among releasing voices first, oldest first; if none are releasing, choose among gated voices, oldest first. Ties go to the lowest index. Pulse steal_pulse.
- Assigned voice on note-on: note id and freq loaded, gate = 1, active = 1, age = 0, release counter cleared.
- Note-on with ev_freq == 0: the oscillator divides by freq, so the event is consumed with no state change and drop_pulse fires.
- Note-off:
  - Target is the lowest-index voice with gate = 1 and a matching note id.
  - Set gate = 0 and load release counter = RELEASE_CYCLES; active stays 1 and freq is unchanged.
  - If no gated voice matches, drop_pulse fires.
  - A note-off for a note that is only releasing is dropped.
- Release counters: each releasing voice decrements its counter every cycle. The transition 1 -> 0 clears active. RELEASE_CYCLES = 0 frees the voice on the next cycle.
- Age counters: every active voice increments its age each cycle, saturating at all-ones. Inactive voices hold age at 0.
- Inactive voices retain their last voice_freq, so oscillators see no glitch.
- Simultaneous events:
  - APPLY targeting a voice whose release expires in the same cycle: APPLY wins; the voice ends gated and active.
  - Decrement and increment on non-targeted voices proceed normally during LOOKUP and APPLY.
- Candidates computed in LOOKUP are valid for APPLY. A release expiring between LOOKUP and APPLY is covered by the simultaneous-event rule above.
- Reset asserted mid-operation: all state returns to reset values immediately; the in-flight event is discarded.
- ev_valid while ev_ready = 0 is not consumed. The source must hold ev_valid and its data stable until the transfer.

Test Plan:
- Reset, then note-on (note 60, 262): voice 0 freq = 262, gate[0] = 1, active[0] = 1. ev_ready is low for exactly 2 cycles. No pulses.
- Four note-ons (60/262, 64/330, 67/392, 72/523), then note-on 76/659 with all gated: voice 0 (oldest) gets 659 and steal_pulse fires once.
- With RELEASE_CYCLES = 10:
  - Note-off on 64: gate[1] = 0, active[1] = 1 for 10 cycles, then active[1] = 0.
  - A note-on issued during that window steals voice 1 in preference to the gated voices.
- Note-on 60/262, then note-on 60/270: the same voice is retriggered with freq = 270, no steal_pulse, and active count is unchanged.
- Note-off for an unheld note 50, and note-on with ev_freq = 0: each gives one drop_pulse and all voice outputs are unchanged.
- Assert rst_n low during LOOKUP after a note-on: all outputs return to reset values, and the first event after release of rst_n lands in voice 0.
